// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART TX serializer between N_REQ TX FIFOs.
// Define UART_TX_ARB_PRIO0_EN to give a non-empty FIFO 0 fixed priority at every arbitration.
module uart_tx_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_fifo_empty,
  output logic [N_REQ-1:0]        o_fifo_ren,
  input  logic [N_REQ*DATA_W-1:0] i_fifo_data,
  output logic [DATA_W-1:0]       o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_t;
  state_t state, state_nx;
  logic [IW-1:0] g, last, win;
  logic [CW-1:0] burst_cnt;
  logic g_empty, release_g;
  assign g_empty = i_fifo_empty[g];
  // Scan from farthest to nearest so the first non-empty index after last wins.
  always_comb begin
    win = last;
    for (int i = N_REQ; i >= 1; i--)
      if (!i_fifo_empty[(int'(last) + i) % N_REQ]) win = IW'((int'(last) + i) % N_REQ);
`ifdef UART_TX_ARB_PRIO0_EN
    if (!i_fifo_empty[0]) win = '0;
`endif
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = &i_fifo_empty ? IDLE : READ;
      READ:    state_nx = g_empty ? IDLE : LOAD;
      LOAD:    state_nx = SEND;
      SEND:    state_nx = !i_tx_ready ? SEND : (burst_cnt < BMAX && !g_empty) ? READ : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign release_g = (state == READ || state == SEND) && state_nx == IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g         <= '0;
      last      <= IW'(N_REQ - 1);
      burst_cnt <= '0;
      o_tx_data <= '0;
    end else begin
      if (state == IDLE && state_nx == READ) begin
        g         <= win;
        burst_cnt <= '0;
      end
      if (state == LOAD) begin
        o_tx_data <= i_fifo_data[g*DATA_W +: DATA_W];
        burst_cnt <= burst_cnt + 1'b1;
      end
`ifdef UART_TX_ARB_PRIO0_EN
      if (release_g && g != '0) last <= g;
`else
      if (release_g) last <= g;
`endif
    end
  end
  assign o_busy     = state != IDLE;
  assign o_tx_valid = state == SEND;
  assign o_grant    = o_busy ? ONE << g : '0;
  assign o_fifo_ren = (state == READ && !g_empty) ? ONE << g : '0;
endmodule
